// File: rtl/pool1_ofm_pingpong_buffer_pkg.sv
// Shared geometry and read-FSM encoding for the pool1 -> conv2 ping-pong buffer.
package pool1_ofm_pingpong_buffer_pkg;

  localparam int DATA_WIDTH        = 32;
  localparam int IFM_SIZE          = 14;  // pool1 output / conv2 input edge
  localparam int IFM_DEPTH         = 6;   // pool1 output / conv2 input channels
  localparam int FMAP_WORDS        = IFM_SIZE * IFM_SIZE;
  localparam int BANK_WORDS        = IFM_DEPTH * FMAP_WORDS;
  localparam int ADDRESS_SIZE_PREV = $clog2(FMAP_WORDS);
  localparam int ADDRESS_SIZE_NEXT = $clog2(BANK_WORDS);

  typedef enum logic [1:0] {
    RD_IDLE      = 2'd0,
    RD_START     = 2'd1,
    RD_WAIT_BUSY = 2'd2,
    RD_WAIT_DONE = 2'd3
  } rd_state_e;

endpackage

// File: rtl/pool1_ofm_pingpong_buffer_pingpong_bank_ram.sv
// Simple dual-port RAM holding both banks; bank select is the address MSB.
// Plain synchronous write and read ports with read-enable so it maps to BRAM.
module pingpong_bank_ram #(
  parameter int DW = 32,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_q;

  // Write port and registered read port; rdata holds when re is low.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/pool1_ofm_pingpong_buffer.sv
// Ping-pong OFM buffer between pool1 and conv2. Pool1 fills one bank a
// channel at a time while conv2 reads the other; full banks are handed over
// with a start pulse / end level handshake.
module pool1_ofm_pingpong_buffer
  import pool1_ofm_pingpong_buffer_pkg::*;
#(
  parameter int DATA_WIDTH        = pool1_ofm_pingpong_buffer_pkg::DATA_WIDTH,
  parameter int IFM_SIZE          = pool1_ofm_pingpong_buffer_pkg::IFM_SIZE,
  parameter int IFM_DEPTH         = pool1_ofm_pingpong_buffer_pkg::IFM_DEPTH,
  parameter int ADDRESS_SIZE_PREV = $clog2(IFM_SIZE * IFM_SIZE),
  parameter int ADDRESS_SIZE_NEXT = $clog2(IFM_DEPTH * IFM_SIZE * IFM_SIZE)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        data_in_from_previous,
  input  logic [ADDRESS_SIZE_PREV-1:0] ifm_address_write_previous,
  input  logic                         ifm_enable_write_previous,
  input  logic                         start_from_previous,
  output logic                         end_to_previous,
  input  logic [ADDRESS_SIZE_NEXT-1:0] ifm_address_read_next,
  input  logic                         ifm_enable_read_next,
  output logic [DATA_WIDTH-1:0]        data_out_for_next,
  output logic                         start_to_next,
  input  logic                         end_from_next,
  output logic                         overflow_error
);

  localparam int FMAP  = IFM_SIZE * IFM_SIZE;
  localparam int BANK  = IFM_DEPTH * FMAP;
  localparam int CH_W  = (IFM_DEPTH > 1) ? $clog2(IFM_DEPTH) : 1;
  localparam int RAM_AW = ADDRESS_SIZE_NEXT + 1;

  logic            wr_sel_q, wr_sel_d;
  logic            rd_sel_q, rd_sel_d;
  logic [CH_W-1:0] ch_cnt_q, ch_cnt_d;
  logic [1:0]      full_q, full_d;
  rd_state_e       state_q, state_d;
  logic            ovf_q, ovf_d;
  logic            rd_zero_q, rd_zero_d;

  logic                         wr_full, wr_addr_ok, wr_fire, release_bank;
  logic                         rd_addr_ok, rd_fire;
  logic [ADDRESS_SIZE_NEXT-1:0] wr_offs;
  logic [DATA_WIDTH-1:0]        ram_rdata;

  assign wr_full    = full_q[wr_sel_q];
  assign wr_addr_ok = 32'(ifm_address_write_previous) < FMAP;
  assign wr_fire    = ifm_enable_write_previous & ~wr_full & wr_addr_ok;
  // Uses the pre-increment channel so a write coinciding with the channel
  // pulse still lands in the channel being closed.
  assign wr_offs    = ADDRESS_SIZE_NEXT'(ch_cnt_q) * ADDRESS_SIZE_NEXT'(FMAP)
                    + ADDRESS_SIZE_NEXT'(ifm_address_write_previous);

  assign rd_addr_ok = 32'(ifm_address_read_next) < BANK;
  assign rd_fire    = ifm_enable_read_next & rd_addr_ok;

  assign end_to_previous   = ~wr_full;
  assign overflow_error    = ovf_q;
  // Out-of-range reads (and the post-reset state) present zero without
  // touching the RAM, so the BRAM output register stays reset-free.
  assign data_out_for_next = rd_zero_q ? '0 : ram_rdata;

  pingpong_bank_ram #(
    .DW (DATA_WIDTH),
    .AW (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_fire),
    .waddr ({wr_sel_q, wr_offs}),
    .wdata (data_in_from_previous),
    .re    (rd_fire),
    .raddr ({rd_sel_q, ifm_address_read_next}),
    .rdata (ram_rdata)
  );

  // Read-side handshake FSM: announce a full bank, then wait for conv2 to
  // go busy and come back idle before releasing it.
  always_comb begin
    state_d       = state_q;
    start_to_next = 1'b0;
    release_bank  = 1'b0;
    case (state_q)
      RD_IDLE:      if (full_q[rd_sel_q] && end_from_next) state_d = RD_START;
      RD_START: begin
        start_to_next = 1'b1;
        state_d       = RD_WAIT_BUSY;
      end
      RD_WAIT_BUSY: if (!end_from_next) state_d = RD_WAIT_DONE;
      RD_WAIT_DONE: if (end_from_next) begin
        release_bank = 1'b1;
        state_d      = RD_IDLE;
      end
      default:      state_d = RD_IDLE;
    endcase
  end

  // Bank bookkeeping: channel counting, fill completion, release, errors.
  // Fill and release in one cycle always hit different banks.
  always_comb begin
    ch_cnt_d  = ch_cnt_q;
    wr_sel_d  = wr_sel_q;
    rd_sel_d  = rd_sel_q;
    full_d    = full_q;
    ovf_d     = ovf_q;
    rd_zero_d = rd_zero_q;
    if (start_from_previous && !wr_full) begin
      if (ch_cnt_q == CH_W'(IFM_DEPTH - 1)) begin
        full_d[wr_sel_q] = 1'b1;
        ch_cnt_d         = '0;
        wr_sel_d         = ~wr_sel_q;
      end else begin
        ch_cnt_d = ch_cnt_q + CH_W'(1);
      end
    end
    if (release_bank) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = ~rd_sel_q;
    end
    if (ifm_enable_write_previous && (wr_full || !wr_addr_ok)) ovf_d = 1'b1;
    if (start_from_previous && wr_full)                        ovf_d = 1'b1;
    if (ifm_enable_read_next) rd_zero_d = ~rd_addr_ok;
  end

  // State registers; bank contents are deliberately not cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_sel_q  <= 1'b0;
      rd_sel_q  <= 1'b0;
      ch_cnt_q  <= '0;
      full_q    <= 2'b00;
      state_q   <= RD_IDLE;
      ovf_q     <= 1'b0;
      rd_zero_q <= 1'b1;
    end else begin
      wr_sel_q  <= wr_sel_d;
      rd_sel_q  <= rd_sel_d;
      ch_cnt_q  <= ch_cnt_d;
      full_q    <= full_d;
      state_q   <= state_d;
      ovf_q     <= ovf_d;
      rd_zero_q <= rd_zero_d;
    end
  end

endmodule

// File: tb/tb_pool1_ofm_pingpong_buffer.sv
// Directed bench for the pool1 -> conv2 ping-pong buffer.
module tb_pool1_ofm_pingpong_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] din = '0;
  logic [7:0]  waddr = '0;
  logic        we = 1'b0;
  logic        sfp = 1'b0;
  logic        e2p;
  logic [10:0] raddr = '0;
  logic        re = 1'b0;
  logic [31:0] dout;
  logic        s2n;
  logic        efn = 1'b1;
  logic        ovf;

  int n_vec = 0;
  int n_err = 0;
  int n_starts = 0;
  int s0;

  pool1_ofm_pingpong_buffer dut (
    .clk                        (clk),
    .reset                      (reset),
    .data_in_from_previous      (din),
    .ifm_address_write_previous (waddr),
    .ifm_enable_write_previous  (we),
    .start_from_previous        (sfp),
    .end_to_previous            (e2p),
    .ifm_address_read_next      (raddr),
    .ifm_enable_read_next       (re),
    .data_out_for_next          (dout),
    .start_to_next              (s2n),
    .end_from_next              (efn),
    .overflow_error             (ovf)
  );

  always #5 clk = ~clk;

  // Count handover pulses as seen at the active edge.
  always @(posedge clk) if (s2n === 1'b1) n_starts++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Integer to IEEE-754 single bits (exact below 2^24).
  function automatic logic [31:0] int2f(input int v);
    int msb;
    logic [31:0] m;
    if (v == 0) return 32'h0;
    msb = 0;
    for (int i = 0; i < 24; i++) if (v[i]) msb = i;
    m = 32'(v) << (23 - msb);
    return {1'b0, 8'(127 + msb), m[22:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_s2n"}, 32'(s2n), 32'd0);
    chk({tag, "_dout"}, dout, 32'd0);
    chk({tag, "_ovf"}, 32'(ovf), 32'd0);
    chk({tag, "_e2p"}, 32'(e2p), 32'd1);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    step();
    step();
    rst_chk(tag);
    reset = 1'b1;
  endtask

  task automatic pulse_ch();
    sfp = 1'b1;
    step();
    sfp = 1'b0;
  endtask

  // One full channel; the channel pulse rides on the last pixel write.
  task automatic fill_ch(input int base, input int ch);
    for (int a = 0; a < 196; a++) begin
      we    = 1'b1;
      waddr = 8'(a);
      din   = int2f(base + ch * 196 + a);
      sfp   = (a == 195);
      step();
    end
    we  = 1'b0;
    sfp = 1'b0;
  endtask

  task automatic rd(input int addr);
    re    = 1'b1;
    raddr = 11'(addr);
    step();
    re    = 1'b0;
  endtask

  initial begin
    // ---- basic fill of bank 0, conv2 ready ----
    efn = 1'b1;
    do_reset("rst0");
    for (int c = 0; c < 6; c++) fill_ch(0, c);
    chk("a_s2n_early", 32'(s2n), 32'd0);
    chk("a_e2p", 32'(e2p), 32'd1);
    step();
    chk("a_s2n_pulse", 32'(s2n), 32'd1);
    step();
    chk("a_s2n_drop", 32'(s2n), 32'd0);
    chk("a_nstarts", 32'(n_starts), 32'd1);
    rd(981);
    chk("a_rd981", dout, 32'h44754000);
    rd(1175);
    chk("a_rd1175", dout, int2f(1175));
    rd(195);
    chk("a_rd195", dout, int2f(195));
    raddr = 11'd5;
    step();
    chk("a_rd_hold", dout, int2f(195));
    rd(1176);
    chk("a_rd_oob", dout, 32'd0);
    chk("a_ovf_pre", 32'(ovf), 32'd0);
    we = 1'b1; waddr = 8'd196; din = 32'h12345678;
    step();
    we = 1'b0;
    chk("a_ovf_addr", 32'(ovf), 32'd1);

    // ---- bank 1 fill while conv2 holds bank 0, then release ----
    for (int c = 0; c < 6; c++) fill_ch(2000, c);
    chk("h_e2p_bothfull", 32'(e2p), 32'd0);
    chk("h_nstarts", 32'(n_starts), 32'd1);
    efn = 1'b0;
    repeat (50) step();
    chk("h_nstarts_busy", 32'(n_starts), 32'd1);
    efn = 1'b1;
    step();
    chk("h_e2p_rel", 32'(e2p), 32'd1);
    chk("h_s2n_idle", 32'(s2n), 32'd0);
    step();
    chk("h_s2n_second", 32'(s2n), 32'd1);
    step();
    chk("h_nstarts2", 32'(n_starts), 32'd2);
    rd(981);
    chk("h_rd_bank1", dout, int2f(2981));

    // ---- both banks full, conv2 never ready ----
    do_reset("rst1");
    efn = 1'b0;
    s0  = n_starts;
    for (int i = 0; i < 11; i++) pulse_ch();
    chk("b_e2p_11", 32'(e2p), 32'd1);
    pulse_ch();
    chk("b_e2p_12", 32'(e2p), 32'd0);
    chk("b_ovf_12", 32'(ovf), 32'd0);
    pulse_ch();
    chk("b_ovf_13", 32'(ovf), 32'd1);
    do_reset("rst2");
    for (int i = 0; i < 12; i++) pulse_ch();
    chk("b2_ovf_pre", 32'(ovf), 32'd0);
    we = 1'b1; waddr = 8'd3; din = 32'hCAFEF00D;
    step();
    we = 1'b0;
    chk("b2_ovf_wr", 32'(ovf), 32'd1);
    chk("b_no_start", 32'(n_starts - s0), 32'd0);

    // ---- reset mid-fill and during WAIT_BUSY ----
    do_reset("rst3");
    efn = 1'b1;
    for (int c = 0; c < 3; c++) fill_ch(3000, c);
    for (int a = 0; a < 10; a++) begin
      we = 1'b1; waddr = 8'(a); din = int2f(3588 + a);
      step();
    end
    we = 1'b0;
    rd(5);
    chk("c_rd_pre", dout, int2f(3005));
    we = 1'b1; waddr = 8'd200;
    step();
    we = 1'b0;
    #2 reset = 1'b0;
    #1 rst_chk("c_async");
    step();
    reset = 1'b1;
    s0 = n_starts;
    for (int c = 0; c < 5; c++) fill_ch(5000, c);
    step(); step();
    chk("c_no_start_5ch", 32'(n_starts - s0), 32'd0);
    chk("c_e2p_5ch", 32'(e2p), 32'd1);
    fill_ch(5000, 5);
    step(); step(); step();
    chk("c_one_start", 32'(n_starts - s0), 32'd1);
    rd(5);
    chk("c_rd_ch0", dout, int2f(5005));
    rd(981);
    chk("c_rd981", dout, int2f(5981));
    #2 reset = 1'b0;
    #1 rst_chk("c_async_busy");
    step();
    reset = 1'b1;
    s0 = n_starts;
    repeat (4) step();
    chk("c_no_restart", 32'(n_starts - s0), 32'd0);

    // ---- final bank-1 channel coincides with bank-0 release ----
    do_reset("rst4");
    efn = 1'b1;
    for (int i = 0; i < 6; i++) pulse_ch();
    step(); step();
    efn = 1'b0;
    step();
    we = 1'b1; waddr = 8'd7; din = 32'hDEADBEEF;
    step();
    we = 1'b0;
    for (int i = 0; i < 5; i++) pulse_ch();
    s0  = n_starts;
    sfp = 1'b1;
    efn = 1'b1;
    step();
    sfp = 1'b0;
    chk("d_e2p", 32'(e2p), 32'd1);
    chk("d_s2n_idle", 32'(s2n), 32'd0);
    step();
    chk("d_s2n", 32'(s2n), 32'd1);
    for (int i = 0; i < 6; i++) pulse_ch();
    chk("d_e2p_full", 32'(e2p), 32'd0);
    chk("d_nstarts", 32'(n_starts - s0), 32'd1);
    rd(7);
    chk("d_rd_bank1", dout, 32'hDEADBEEF);
    chk("d_ovf", 32'(ovf), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
